visumon_slot_arbiter: RTL
=========================

# visumon_slot_arbiter

Shares the 64-slot debug display of the VGA LED monitor between up to `NREQ` requester blocks. Requesters post (slot, value) writes over a valid/ready handshake. A round-robin arbiter grants one write per clock into a slot register file. The render path reads slots by index with one-cycle latency; optional double-buffering commits writes only at frame boundaries, which prevents tearing.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `DW`, 8, data bits per slot

Ports:
- `i_clk25Mhz`  in  1  pixel clock; the only clock
- `i_reset`  in  1  synchronous, active-high reset
- `i_reqValid`  in  NREQ  per-requester write request
- `i_reqSlot`  in  NREQ*6  slot index; requester k occupies bits [6k+5:6k]
- `i_reqData`  in  NREQ*DW  write value; requester k occupies bits [DW*k+DW-1:DW*k]
- `o_reqReady`  out  NREQ  one-hot grant, combinational from valid and pointer
- `i_frameStrobe`  in  1  one-cycle pulse at start of vertical blanking
- `i_rdSlot`  in  6  display read index
- `o_rdData`  out  DW  registered read data of the display array
- `o_commit`  out  1  one-cycle pulse when the staging array is copied to the display array
- `o_dirty`  out  1  staging array holds uncommitted writes

## Operation
- Storage:
  - display array `disp[0:63]`, DW bits each.
  - With double-buffering, a staging array `stag[0:63]` and a `dirty` flag are added.
- Arbitration:
  - Register `last` holds the index of the most recent grant.
  - Grant goes to the first requester with valid set, searching `last+1, last+2, …` modulo NREQ.
  - `o_reqReady` is that single bit; all bits are 0 when no valid is set.
  - A transfer occurs when valid and ready are both 1 on the same clock edge.
  - On a transfer, `last` takes the granted index. Otherwise `last` holds.
- Write: a transfer writes `i_reqData[k]` to slot `i_reqSlot[k]` of the write target:
  - `stag` with double-buffering;
  - `disp` without it.
- Requesters must hold valid, slot and data stable until ready. Dropping valid before the grant is legal and loses nothing.
- Commit (double-buffering only): when `i_frameStrobe` = 1 and `dirty` = 1, all 64 entries of `stag` are copied to `disp` in one cycle. `dirty` clears and `o_commit` pulses.
- Commit with `dirty` = 0 does nothing; `o_commit` stays 0.
- Simultaneous transfer and commit:
  - the copy uses `stag` contents from before the edge;
  - the new write lands in `stag`;
  - `dirty` is 1 after the edge.
- Duplicate slot: writes from different requesters to the same slot apply in grant order; the last grant wins.
- Reset values, forced on the next clock edge while `i_reset` = 1:
  - all `disp` and `stag` entries = 0;
  - `dirty` = 0, `o_commit` = 0, `o_rdData` = 0;
  - `last` = NREQ-1, so requester 0 wins the first arbitration.
- While `i_reset` = 1, `o_reqReady` = 0 and no transfers occur.
- Reset mid-frame discards all pending staging content.

## Timing
- Throughput: one write per cycle, aggregate across all requesters.
- Grant: combinational, in the same cycle as valid.
- Written value visibility on `o_rdData`:
  - without double-buffering: read in the cycle after the transfer, data out 1 cycle later (transfer edge +2);
  - with double-buffering: at commit edge +1 read, +2 data.
- Starvation bound: a requester holding valid is granted within NREQ cycles.
- `o_commit` is registered and rises on the edge after `i_frameStrobe` is sampled.
- `o_dirty` is a registered copy of `dirty`.
- `i_frameStrobe` longer than one cycle: commits again only if new writes set `dirty`.

## Configuration
- Macro: `VISUMON_TEARFREE_EN`.
- Defined:
  - staging array, `dirty` flag and commit logic are present;
  - `o_commit` and `o_dirty` behave as above.
- Undefined:
  - writes go straight to `disp`;
  - `stag` is absent;
  - `o_commit` and `o_dirty` are tied 0;
  - `i_frameStrobe` is ignored.

## Test plan
- Reset: assert `i_reset` 2 cycles with requests pending.
  - During reset: ready = 0.
  - After reset: reading slots 0, 31, 63 returns 0 on `o_rdData`; `o_dirty` = 0.
- Round-robin, NREQ=4: all valid held, each targeting slot = its index.
  - Grant sequence is 0,1,2,3,0.
  - Slots 0..3 hold the requester data.
- Direct mode (macro off): req1 writes slot 42 = 0xA5.
  - Read slot 42 in the next cycle; `o_rdData` = 0xA5 one cycle later.
- Tear-free (macro on): req0 writes slot 5 = 0x3C.
  - Before strobe: slot 5 reads 0, `o_dirty` = 1.
  - After strobe: `o_commit` pulses once and slot 5 reads 0x3C.
- Simultaneous event (macro on): req2 writes slot 7 = 0x11 on the same edge as the strobe.
  - Commit copies the old staging; slot 7 still reads the old value.
  - `o_dirty` = 1; the next strobe makes slot 7 read 0x11.
- Collision: req0 and req3 both write slot 9, with `last` = 1.
  - Req3 is granted first, req0 second.
  - Slot 9 ends with req0 data; empty strobe with `dirty` = 0 gives no `o_commit`.

Source files
------------

// File: rtl/visumon_slot_arbiter.sv
// visumon_slot_arbiter
//   Shares the 64-slot debug display of the VGA LED monitor between NREQ
//   requesters. A round-robin arbiter accepts one (slot, value) write per
//   clock into the slot register file; the render path reads one slot per
//   clock with one cycle of latency.
//
//   Build option VISUMON_TEARFREE_EN: when defined, writes land in a staging
//   array that is copied to the display array on a frame strobe, so a frame
//   never shows a half-updated set of slots. When undefined, writes go
//   straight to the display array and o_commit / o_dirty are held at 0.
//
// Ports
//   i_clk25Mhz     pixel clock, the only clock
//   i_reset        synchronous active-high reset
//   i_reqValid     per-requester write request
//   i_reqSlot      6-bit slot index per requester, requester k at [6k+5:6k]
//   i_reqData      DW-bit value per requester, requester k at [DW*k+DW-1:DW*k]
//   o_reqReady     one-hot grant, combinational from valid and last grant
//   i_frameStrobe  one-cycle pulse at start of vertical blanking
//   i_rdSlot       display read index
//   o_rdData       registered display read data
//   o_commit       one-cycle pulse when staging is copied to display
//   o_dirty        staging holds uncommitted writes
module visumon_slot_arbiter #(
   parameter int NREQ = 4,
   parameter int DW   = 8
) (
   input  logic                 i_clk25Mhz,
   input  logic                 i_reset,
   input  logic [NREQ-1:0]      i_reqValid,
   input  logic [NREQ*6-1:0]    i_reqSlot,
   input  logic [NREQ*DW-1:0]   i_reqData,
   output logic [NREQ-1:0]      o_reqReady,
   input  logic                 i_frameStrobe,
   input  logic [5:0]           i_rdSlot,
   output logic [DW-1:0]        o_rdData,
   output logic                 o_commit,
   output logic                 o_dirty
);

   localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [LW-1:0]   last;
   logic [LW-1:0]   cand;
   logic [LW-1:0]   gidx;
   logic            found;
   logic [NREQ-1:0] grant;
   logic            xfer;
   logic [5:0]      wslot;
   logic [DW-1:0]   wdata;
   logic [DW-1:0]   disp [64];
   logic [DW-1:0]   rd_data;

   // Walk the requesters starting just after the last grant; the first
   // valid one found wins. The explicit wrap keeps non-power-of-two NREQ
   // inside 0..NREQ-1.
   always_comb begin
      grant = '0;
      gidx  = last;
      found = 1'b0;
      cand  = last;
      for (int i = 0; i < NREQ; i++) begin
         cand = (cand == LW'(NREQ - 1)) ? '0 : cand + LW'(1);
         if (!found && i_reqValid[cand]) begin
            found       = 1'b1;
            gidx        = cand;
            grant[cand] = 1'b1;
         end
      end
      if (i_reset) begin
         grant = '0;
      end
   end

   always_comb begin
      wslot = '0;
      wdata = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (grant[k]) begin
            wslot = i_reqSlot[6*k +: 6];
            wdata = i_reqData[DW*k +: DW];
         end
      end
   end

   assign o_reqReady = grant;
   assign xfer       = |grant;

   always_ff @(posedge i_clk25Mhz) begin
      if (i_reset) begin
         last <= LW'(NREQ - 1);
      end else if (xfer) begin
         last <= gidx;
      end
   end

   always_ff @(posedge i_clk25Mhz) begin
      if (i_reset) begin
         rd_data <= '0;
      end else begin
         rd_data <= disp[i_rdSlot];
      end
   end

   assign o_rdData = rd_data;

`ifdef VISUMON_TEARFREE_EN
   logic [DW-1:0] stag [64];
   logic          dirty;
   logic          commit_q;
   logic          do_commit;

   assign do_commit = i_frameStrobe & dirty;

   // The copy reads stag before this edge, so a write granted on the same
   // edge stays in staging and keeps dirty set for the next frame.
   always_ff @(posedge i_clk25Mhz) begin
      if (i_reset) begin
         for (int s = 0; s < 64; s++) begin
            disp[s] <= '0;
            stag[s] <= '0;
         end
         dirty    <= 1'b0;
         commit_q <= 1'b0;
      end else begin
         commit_q <= do_commit;
         if (do_commit) begin
            for (int s = 0; s < 64; s++) begin
               disp[s] <= stag[s];
            end
         end
         if (xfer) begin
            stag[wslot] <= wdata;
            dirty       <= 1'b1;
         end else if (i_frameStrobe) begin
            dirty <= 1'b0;
         end
      end
   end

   assign o_commit = commit_q;
   assign o_dirty  = dirty;
`else
   logic unused_strobe;

   assign unused_strobe = i_frameStrobe;

   always_ff @(posedge i_clk25Mhz) begin
      if (i_reset) begin
         for (int s = 0; s < 64; s++) begin
            disp[s] <= '0;
         end
      end else if (xfer) begin
         disp[wslot] <= wdata;
      end
   end

   assign o_commit = 1'b0;
   assign o_dirty  = 1'b0;
`endif

endmodule
